// File: rtl/gnrl_multichannel_delayed_pulser.sv
// gnrl_multichannel_delayed_pulser
//
// One rising edge on SIG_IN starts NUM_CH independent channels. Each channel
// waits its own delay, then drives one pulse of its own width. Sequence status
// is reported on BUSY, DONE and OVERRUN.
//
// Optional feature macro: GNRL_PULSER_RETRIGGER_EN
//   undefined : a trigger while BUSY is ignored (OVERRUN pulses).
//   defined   : a trigger while BUSY aborts the sequence and restarts every
//               channel on the newly latched schedule (OVERRUN pulses, no DONE).
//
// Ports
//   CLK          in   system clock, rising edge
//   RESET_n      in   asynchronous active-low reset
//   SIG_IN       in   trigger, synchronous to CLK (rising edge detected)
//   DELAY        in   NUM_CH x DELAY_WIDTH per-channel delay, ch i at [i*DELAY_WIDTH +: DELAY_WIDTH]
//   PULSE_WIDTH  in   NUM_CH x WIDTH_WIDTH per-channel pulse width, packed the same way
//   CH_EN        in   per-channel enable
//   SIG_OUT      out  registered per-channel pulse outputs
//   BUSY         out  high while a sequence is in progress
//   DONE         out  one-cycle pulse when a sequence completes
//   OVERRUN      out  one-cycle pulse when a trigger arrives during a running sequence

module gnrl_multichannel_delayed_pulser #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DELAY_WIDTH = 16,
    parameter int unsigned WIDTH_WIDTH = 16
) (
    input  logic                            CLK,
    input  logic                            RESET_n,
    input  logic                            SIG_IN,
    input  logic [NUM_CH*DELAY_WIDTH-1:0]   DELAY,
    input  logic [NUM_CH*WIDTH_WIDTH-1:0]   PULSE_WIDTH,
    input  logic [NUM_CH-1:0]               CH_EN,
    output logic [NUM_CH-1:0]               SIG_OUT,
    output logic                            BUSY,
    output logic                            DONE,
    output logic                            OVERRUN
);

    // One counter serves both phases, so it must hold the wider of the two values.
    localparam int unsigned CntW = (DELAY_WIDTH > WIDTH_WIDTH) ? DELAY_WIDTH : WIDTH_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StPulse
    } ch_state_e;

    ch_state_e              state_q [NUM_CH];
    ch_state_e              state_d [NUM_CH];
    logic [CntW-1:0]        cnt_q   [NUM_CH];
    logic [CntW-1:0]        cnt_d   [NUM_CH];
    logic [WIDTH_WIDTH-1:0] width_q [NUM_CH];
    logic [WIDTH_WIDTH-1:0] width_d [NUM_CH];

    logic              sig_in_q;
    logic [NUM_CH-1:0] sig_out_q, sig_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;

    logic all_idle;
    logic trig;
    logic running;
    logic busy_ending;
    logic accept;

    // ------------------------------------------------------------------
    // Sequence control
    // ------------------------------------------------------------------
    always_comb begin
        all_idle = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (state_q[i] != StIdle) begin
                all_idle = 1'b0;
            end
        end
    end

    assign trig        = SIG_IN & ~sig_in_q;
    // BUSY with every channel idle only happens on the edge that ends a sequence,
    // so a trigger there starts a fresh sequence rather than colliding.
    assign busy_ending = busy_q & all_idle;
    assign running     = busy_q & ~all_idle;

`ifdef GNRL_PULSER_RETRIGGER_EN
    assign accept = trig;
`else
    assign accept = trig & ~running;
`endif

    always_comb begin
        busy_d    = busy_q;
        done_d    = busy_ending;
        overrun_d = trig & running;
        if (accept) begin
            busy_d = 1'b1;
        end else if (busy_ending) begin
            busy_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel delay/pulse FSMs
    // ------------------------------------------------------------------
    // The delay is latched straight into the counter and the enable is consumed
    // by the IDLE->WAIT decision, so only the width needs its own register.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            width_d[i] = width_q[i];

            if (accept) begin
                width_d[i] = PULSE_WIDTH[i*WIDTH_WIDTH +: WIDTH_WIDTH];
                if (CH_EN[i] && (PULSE_WIDTH[i*WIDTH_WIDTH +: WIDTH_WIDTH] != '0)) begin
                    state_d[i] = StWait;
                    cnt_d[i]   = CntW'(DELAY[i*DELAY_WIDTH +: DELAY_WIDTH]);
                end else begin
                    state_d[i] = StIdle;
                    cnt_d[i]   = '0;
                end
            end else begin
                unique case (state_q[i])
                    StIdle: begin
                        cnt_d[i] = '0;
                    end
                    StWait: begin
                        if (cnt_q[i] == '0) begin
                            state_d[i] = StPulse;
                            cnt_d[i]   = CntW'(width_q[i]);
                        end else begin
                            cnt_d[i] = cnt_q[i] - CntW'(1);
                        end
                    end
                    StPulse: begin
                        // Width is nonzero here, so the counter never wraps.
                        if (cnt_q[i] == CntW'(1)) begin
                            state_d[i] = StIdle;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CntW'(1);
                        end
                    end
                    default: begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = '0;
                    end
                endcase
            end

            sig_out_d[i] = (state_d[i] == StPulse);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            sig_in_q  <= 1'b0;
            sig_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
                width_q[i] <= '0;
            end
        end else begin
            sig_in_q  <= SIG_IN;
            sig_out_q <= sig_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                width_q[i] <= width_d[i];
            end
        end
    end

    assign SIG_OUT = sig_out_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_gnrl_multichannel_delayed_pulser.sv
// Self-checking bench for gnrl_multichannel_delayed_pulser (NUM_CH=4, 16-bit fields).
// A schedule-level reference model predicts every output after every clock edge;
// table vectors and hand-written sequences add independent expectations.

module tb_gnrl_multichannel_delayed_pulser;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int WW  = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sig_in;
    logic [NCH*DW-1:0]  delay;
    logic [NCH*WW-1:0]  pw;
    logic [NCH-1:0]     ch_en;
    logic [NCH-1:0]     sig_out;
    logic               busy, done, overrun;

    gnrl_multichannel_delayed_pulser #(
        .NUM_CH      (NCH),
        .DELAY_WIDTH (DW),
        .WIDTH_WIDTH (WW)
    ) dut (
        .CLK         (clk),
        .RESET_n     (rst_n),
        .SIG_IN      (sig_in),
        .DELAY       (delay),
        .PULSE_WIDTH (pw),
        .CH_EN       (ch_en),
        .SIG_OUT     (sig_out),
        .BUSY        (busy),
        .DONE        (done),
        .OVERRUN     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (schedule arithmetic) ----------------
    int n = 0;          // index of the most recent clock edge
    bit has_seq, busy_m, done_m, ov_m, prev_m;
    int k_m, end_m;
    int d_m [NCH];
    int w_m [NCH];
    bit act_m [NCH];

    task automatic model_reset();
        has_seq = 0; busy_m = 0; done_m = 0; ov_m = 0; prev_m = 0;
    endtask

    task automatic model_accept();
        int mx;
        mx = -1;
        k_m = n;
        has_seq = 1;
        busy_m = 1;
        for (int c = 0; c < NCH; c++) begin
            d_m[c]   = int'(delay[c*DW +: DW]);
            w_m[c]   = int'(pw[c*WW +: WW]);
            act_m[c] = ch_en[c] && (w_m[c] != 0);
            if (act_m[c] && (d_m[c] + w_m[c] > mx)) mx = d_m[c] + w_m[c];
        end
        end_m = (mx < 0) ? n + 1 : n + 2 + mx;
    endtask

    task automatic model_edge();
        bit trig;
        n++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        trig   = sig_in && !prev_m;
        prev_m = sig_in;
        done_m = 0;
        ov_m   = 0;
        if (busy_m && n == end_m) begin
            busy_m = 0;
            done_m = 1;
        end
        if (trig) begin
            if (busy_m) begin
                ov_m = 1;
`ifdef GNRL_PULSER_RETRIGGER_EN
                model_accept();
`endif
            end else begin
                model_accept();
            end
        end
    endtask

    function automatic logic [NCH-1:0] exp_sig();
        logic [NCH-1:0] e;
        e = '0;
        for (int c = 0; c < NCH; c++)
            e[c] = has_seq && act_m[c] && (n >= k_m + 1 + d_m[c]) && (n < k_m + 1 + d_m[c] + w_m[c]);
        return e;
    endfunction

    // One clock edge: advance the model, then compare 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_sig_out", 32'(sig_out), 32'(exp_sig()));
        chk("model_busy",    32'(busy),    32'(busy_m));
        chk("model_done",    32'(done),    32'(done_m));
        chk("model_overrun", 32'(overrun), 32'(ov_m));
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy_m || busy) && guard < 3000) begin
            cycle();
            guard++;
        end
        chk("wait_idle_busy", 32'(busy), 32'(0));
        cycle();
    endtask

    task automatic set_cfg(input logic [NCH*DW-1:0] d, input logic [NCH*WW-1:0] p,
                           input logic [NCH-1:0] e);
        delay = d; pw = p; ch_en = e;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [NCH*DW-1:0] dly;
        logic [NCH*WW-1:0] pw;
        logic [NCH-1:0]    en;
        logic [3:0][7:0]   rise;   // offset from trigger edge of first high sample
        logic [3:0][7:0]   len;    // cycles high, 0 = never
        int                clr;    // offset at which BUSY clears / DONE rises
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{dly: {16'd1, 16'd1, 16'd1, 16'd10}, pw: {16'd5, 16'd5, 16'd5, 16'd3}, en: 4'b0001,
                    rise: {8'd0, 8'd0, 8'd0, 8'd11}, len: {8'd0, 8'd0, 8'd0, 8'd3}, clr: 15};
        vecs[1] = '{dly: {16'd7, 16'd2, 16'd5, 16'd0}, pw: {16'd1, 16'd2, 16'd4, 16'd1}, en: 4'b1111,
                    rise: {8'd8, 8'd3, 8'd6, 8'd1}, len: {8'd1, 8'd2, 8'd4, 8'd1}, clr: 11};
        vecs[2] = '{dly: {16'd1, 16'd1, 16'd1, 16'd3}, pw: {16'd1, 16'd3, 16'd0, 16'd2}, en: 4'b1011,
                    rise: {8'd2, 8'd0, 8'd0, 8'd4}, len: {8'd1, 8'd0, 8'd0, 8'd2}, clr: 7};
        vecs[3] = '{dly: {16'd0, 16'd0, 16'd0, 16'd0}, pw: {16'd4, 16'd4, 16'd4, 16'd4}, en: 4'b0000,
                    rise: {8'd0, 8'd0, 8'd0, 8'd0}, len: {8'd0, 8'd0, 8'd0, 8'd0}, clr: 1};
        vecs[4] = '{dly: {16'd2, 16'd2, 16'd2, 16'd2}, pw: {16'd3, 16'd3, 16'd0, 16'd3}, en: 4'b0010,
                    rise: {8'd0, 8'd0, 8'd0, 8'd0}, len: {8'd0, 8'd0, 8'd0, 8'd0}, clr: 1};
        vecs[5] = '{dly: {16'd0, 16'd0, 16'd0, 16'd0}, pw: {16'd0, 16'd1, 16'd0, 16'd0}, en: 4'b0100,
                    rise: {8'd0, 8'd1, 8'd0, 8'd0}, len: {8'd0, 8'd1, 8'd0, 8'd0}, clr: 3};

        // ---------------- reset ----------------
        rst_n = 1'b0; sig_in = 1'b0;
        set_cfg('0, '0, '0);
        model_reset();
        #2;
        chk("reset_sig_out", 32'(sig_out), 32'(0));
        chk("reset_busy",    32'(busy),    32'(0));
        chk("reset_done",    32'(done),    32'(0));
        chk("reset_overrun", 32'(overrun), 32'(0));
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // ---------------- table-driven vectors ----------------
        for (int v = 0; v < 6; v++) begin
            set_cfg(vecs[v].dly, vecs[v].pw, vecs[v].en);
            sig_in = 1'b1;
            for (int off = 0; off <= vecs[v].clr + 2; off++) begin
                logic [NCH-1:0] e;
                cycle();
                if (off == 0) begin
                    // Scramble inputs after the trigger edge: the schedule is latched.
                    sig_in = 1'b0;
                    set_cfg({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom));
                end
                for (int c = 0; c < NCH; c++)
                    e[c] = (vecs[v].len[c] != 0) && (off >= int'(vecs[v].rise[c]))
                           && (off < int'(vecs[v].rise[c]) + int'(vecs[v].len[c]));
                chk($sformatf("vec%0d_sig_out_off%0d", v, off), 32'(sig_out), 32'(e));
                chk($sformatf("vec%0d_busy_off%0d", v, off), 32'(busy), 32'(off < vecs[v].clr));
                chk($sformatf("vec%0d_done_off%0d", v, off), 32'(done), 32'(off == vecs[v].clr));
            end
            wait_idle();
        end

        // ---------------- trigger while busy ----------------
        set_cfg({16'd0, 16'd0, 16'd0, 16'd10}, {16'd0, 16'd0, 16'd0, 16'd100}, 4'b0001);
        sig_in = 1'b1;
        cycle();                       // edge k
        sig_in = 1'b0;
        for (int off = 1; off <= 19; off++) cycle();
        sig_in = 1'b1;
        cycle();                       // edge k+20
        chk("busy_retrig_overrun", 32'(overrun), 32'(1));
        sig_in = 1'b0;
        cycle();
        chk("busy_retrig_overrun_clear", 32'(overrun), 32'(0));
        for (int off = 22; off <= 25; off++) cycle();
`ifdef GNRL_PULSER_RETRIGGER_EN
        chk("busy_retrig_mid", 32'(sig_out[0]), 32'(0));
`else
        chk("busy_retrig_mid", 32'(sig_out[0]), 32'(1));
`endif
        for (int off = 26; off <= 31; off++) cycle();
        chk("busy_retrig_k31", 32'(sig_out[0]), 32'(1));
        wait_idle();

        // ---------------- back-to-back on BUSY-clear edge ----------------
        set_cfg({16'd0, 16'd0, 16'd0, 16'd2}, {16'd0, 16'd0, 16'd0, 16'd2}, 4'b0001);
        sig_in = 1'b1;
        cycle();                       // edge k, clear expected at k+6
        sig_in = 1'b0;
        for (int off = 1; off <= 5; off++) cycle();
        sig_in = 1'b1;
        cycle();                       // edge k+6
        chk("b2b_done",    32'(done),    32'(1));
        chk("b2b_busy",    32'(busy),    32'(1));
        chk("b2b_overrun", 32'(overrun), 32'(0));
        sig_in = 1'b0;
        for (int off = 7; off <= 9; off++) cycle();
        chk("b2b_second_pulse", 32'(sig_out[0]), 32'(1));
        for (int off = 10; off <= 12; off++) cycle();
        chk("b2b_second_done", 32'(done), 32'(1));
        wait_idle();

        // ---------------- async reset mid-pulse, SIG_IN held through reset ----------------
        set_cfg({16'd0, 16'd0, 16'd0, 16'd2}, {16'd0, 16'd0, 16'd0, 16'd20}, 4'b0001);
        sig_in = 1'b1;
        cycle();
        for (int off = 1; off <= 5; off++) cycle();
        chk("pre_reset_pulse", 32'(sig_out[0]), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("async_reset_sig_out", 32'(sig_out), 32'(0));
        chk("async_reset_busy",    32'(busy),    32'(0));
        chk("async_reset_done",    32'(done),    32'(0));
        chk("async_reset_overrun", 32'(overrun), 32'(0));
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("held_high_first_edge_busy", 32'(busy), 32'(1));
        sig_in = 1'b0;
        wait_idle();

        // ---------------- randomized run against the model ----------------
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) sig_in = ~sig_in;
            if ($urandom_range(0, 3) == 0) begin
                for (int c = 0; c < NCH; c++) begin
                    delay[c*DW +: DW] = 16'($urandom_range(0, 12));
                    pw[c*WW +: WW]    = 16'($urandom_range(0, 5));
                end
                ch_en = 4'($urandom);
            end
            rst_n = ($urandom_range(0, 399) != 0);
            cycle();
        end
        rst_n = 1'b1;
        sig_in = 1'b0;
        cycle();
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
